// File: rtl/fifo_wr_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb_pkg
// Shared definitions for the FIFO write-port arbiter:
//   - N_REQ / DATA_W : requester count and FIFO word width
//   - PTR_W          : width of the round-robin pointer / grant index
//   - state_e        : arbiter FSM state encoding (IDLE, BURST, DONE)
//   - onehot_idx()   : converts a one-hot grant into its requester index
// -----------------------------------------------------------------------------
package fifo_wr_arb_pkg;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 32;
  localparam int PTR_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Index of the set bit in a one-hot vector; 0 for an all-zero vector.
  function automatic logic [PTR_W-1:0] onehot_idx(input logic [N_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches the request vector starting at
// the pointer position and moving upward modulo N_REQ; the first set bit wins.
//   req_i  in  N_REQ : request vector
//   ptr_i  in  PTR_W : index with highest priority
//   gnt_o  out N_REQ : one-hot winner (0 when nothing requests)
//   vld_o  out 1     : at least one request present
// -----------------------------------------------------------------------------
module rr_pick
  import fifo_wr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             vld_o
);

  // Walk from the lowest-priority offset to the highest so that the last
  // overwrite is the requester closest to the pointer. The 2-bit sum wraps
  // naturally, giving the modulo-4 search order.
  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_i[ptr_i + PTR_W'(k)]) begin
        gnt_o                      = '0;
        gnt_o[ptr_i + PTR_W'(k)]   = 1'b1;
        vld_o                      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb
// Round-robin write arbiter sharing one FIFO write port among four producers.
// A requester is granted for a burst of at most BURST_MAX words; the burst ends
// on req_last, on reaching BURST_MAX, or when the requester drops req while the
// FIFO is not full. Writes stall (grant held, no timeout) while fifo_full is set.
//
// Parameters: N_REQ (4), DATA_W (32), BURST_MAX (1..8, default 4)
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req, req_last       : per-requester word valid / final-word marker
//   req_data            : requester i data on [DATA_W*i +: DATA_W]
//   gnt                 : registered one-hot grant
//   ack                 : word of the granted requester accepted this cycle
//   fifo_full           : FIFO full flag
//   fifo_wr_err         : FIFO write-error flag (only observed with stats)
//   fifo_wr_en/fifo_d_in: FIFO write strobe and data (data is 0 when idle)
//   busy                : FSM is not in IDLE
// Optional feature, enabled by defining FIFO_WR_ARB_STATS_EN:
//   acc_cnt (N_REQ x 16b) : saturating per-requester accepted-word counters
//   ovf_err               : sticky flag set by fifo_wr_err
// Both statistics clear only on reset.
// -----------------------------------------------------------------------------
module fifo_wr_arb #(
  parameter int N_REQ     = fifo_wr_arb_pkg::N_REQ,
  parameter int DATA_W    = fifo_wr_arb_pkg::DATA_W,
  parameter int BURST_MAX = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        ack,
  input  logic                    fifo_full,
  input  logic                    fifo_wr_err,
  output logic                    fifo_wr_en,
  output logic [DATA_W-1:0]       fifo_d_in,
  output logic                    busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]     acc_cnt,
  output logic                    ovf_err
`endif
);

  import fifo_wr_arb_pkg::*;

  localparam logic [3:0] BURST_MAX_C = 4'(BURST_MAX);

  // Control state
  state_e           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [PTR_W-1:0] rr_ptr_q;
  logic [3:0]       burst_cnt_q;
  logic [3:0]       burst_cnt_d;

  // Arbitration and acceptance terms
  logic [N_REQ-1:0] pick_gnt;
  logic             pick_vld;
  logic [PTR_W-1:0] g_idx;
  logic             accept;
  logic             abandon;
  logic             burst_end;

  rr_pick u_rr_pick (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .vld_o (pick_vld)
  );

  assign g_idx = onehot_idx(gnt_q);

  // A drop of req[g] only counts as abandonment when the FIFO can take data;
  // while full the grant is simply held.
  assign accept      = (state_q == BURST) && req[g_idx] && !fifo_full;
  assign abandon     = (state_q == BURST) && !req[g_idx] && !fifo_full;
  assign burst_cnt_d = burst_cnt_q + 4'd1;
  assign burst_end   = accept && (req_last[g_idx] || (burst_cnt_d == BURST_MAX_C));

  // Acceptance outputs are combinational so the first word moves in the
  // same cycle the grant appears.
  assign fifo_wr_en = accept;
  assign ack        = accept ? gnt_q : '0;
  assign fifo_d_in  = accept ? req_data[g_idx*DATA_W +: DATA_W] : '0;
  assign gnt        = gnt_q;
  assign busy       = (state_q != IDLE);

  // ---- FSM: IDLE arbitrates, BURST moves words, DONE rotates priority ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            gnt_q       <= pick_gnt;
            burst_cnt_q <= '0;
            state_q     <= BURST;
          end
        end
        BURST: begin
          if (accept) burst_cnt_q <= burst_cnt_d;
          // req_last on the BURST_MAX-th word is a single end condition.
          if (burst_end || abandon) state_q <= DONE;
        end
        DONE: begin
          // The requester just served drops to lowest priority; 3 wraps to 0.
          gnt_q    <= '0;
          rr_ptr_q <= g_idx + PTR_W'(1);
          state_q  <= IDLE;
        end
        default: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [N_REQ*16-1:0] acc_cnt_q;
  logic                ovf_err_q;

  // ---- Statistics: per-requester accepted words and sticky write error ----
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_cnt_q <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (ack[i]) acc_cnt_q[16*i +: 16] <= sat_inc16(acc_cnt_q[16*i +: 16]);
      end
      if (fifo_wr_err) ovf_err_q <= 1'b1;
    end
  end

  assign acc_cnt = acc_cnt_q;
  assign ovf_err = ovf_err_q;
`else
  // The write-error flag is only meaningful to the statistics block.
  logic unused_fifo_wr_err;
  assign unused_fifo_wr_err = fifo_wr_err;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arb
// Producers are modelled as per-requester word queues. Each cycle a
// transaction-level reference predicts grant/busy/write behaviour and pushes
// the expected write (requester, data) into a scoreboard; an independent
// monitor pops and compares whenever the DUT writes.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arb;

  localparam int BMAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req, req_last;
  logic [127:0]  req_data;
  logic [3:0]    gnt, ack;
  logic          fifo_full, fifo_wr_err;
  logic          fifo_wr_en;
  logic [31:0]   fifo_d_in;
  logic          busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [63:0]   acc_cnt;
  logic          ovf_err;
`endif

  always #5 clk = ~clk;

  fifo_wr_arb #(.BURST_MAX(BMAX)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_last    (req_last),
    .req_data    (req_data),
    .gnt         (gnt),
    .ack         (ack),
    .fifo_full   (fifo_full),
    .fifo_wr_err (fifo_wr_err),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_d_in   (fifo_d_in),
    .busy        (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .acc_cnt     (acc_cnt),
    .ovf_err     (ovf_err)
`endif
  );

  typedef struct packed { logic [31:0] data; logic last; } word_t;
  typedef struct packed { logic [3:0] gnt; logic busy; logic wr; } cyc_t;
  typedef struct packed { logic [1:0] idx; logic [31:0] data; } wr_t;

  word_t      pq [4][$];   // producer word queues (head = word on req_data)
  cyc_t       exp_cyc[$];  // expected per-cycle grant / busy / write strobe
  wr_t        exp_wr[$];   // expected FIFO writes in order
  logic [3:0] gseq[$];     // observed sequence of new grants

  int checks = 0, errors = 0;
  int dut_wr = 0, n_exp_wr = 0;
  bit mon_on = 0;
  logic err_now = 1'b0;

  // Reference: mode 0 = arbitrate, 1 = transferring burst, 2 = hand-over cycle
  int m_mode, m_cur, m_cnt, m_ptr;
  int m_acc[4];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endfunction

  // One clock cycle: drive producers, then predict what the arbiter must do.
  task automatic step(input logic rst, input logic full, input logic [3:0] drop);
    logic [3:0] r;
    bit acc, fin;
    int k;
    @(negedge clk);
    reset       = rst;
    fifo_full   = full;
    fifo_wr_err = err_now;
    for (int i = 0; i < 4; i++) begin
      r[i]                  = (pq[i].size() > 0) && !drop[i];
      req_data[32*i +: 32]  = (pq[i].size() > 0) ? pq[i][0].data : 32'h0;
      req_last[i]           = (pq[i].size() > 0) ? pq[i][0].last : 1'b0;
    end
    req = r;
    #1;
    acc = 0;
    fin = 0;
    if (m_mode == 0) begin
      exp_cyc.push_back('{4'b0000, 1'b0, 1'b0});
      if (!rst && r != 4'b0000) begin
        k = 0;
        while (!r[(m_ptr + k) % 4]) k++;
        m_cur  = (m_ptr + k) % 4;
        m_cnt  = 0;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      acc = r[m_cur] && !full;
      exp_cyc.push_back('{4'(1 << m_cur), 1'b1, acc});
      if (acc) begin
        exp_wr.push_back('{2'(m_cur), pq[m_cur][0].data});
        n_exp_wr++;
        m_cnt++;
        fin = pq[m_cur][0].last || (m_cnt == BMAX);
        if (m_acc[m_cur] < 65535) m_acc[m_cur]++;
        void'(pq[m_cur].pop_front());
      end else if (!r[m_cur] && !full) begin
        fin = 1;
      end
      if (fin) m_mode = 2;
    end else begin
      exp_cyc.push_back('{4'(1 << m_cur), 1'b1, 1'b0});
      m_ptr  = (m_cur + 1) % 4;
      m_mode = 0;
    end
    if (rst) begin
      m_mode = 0;
      m_ptr  = 0;
      m_cnt  = 0;
      for (int i = 0; i < 4; i++) m_acc[i] = 0;
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < 4; i++) pq[i].delete();
  endtask

  // Monitor: samples 2 time units after the stimulus edge, away from posedge.
  initial begin
    logic [3:0] prev_gnt;
    cyc_t ec;
    wr_t  ew;
    prev_gnt = 4'b0000;
    forever begin
      @(negedge clk);
      #2;
      if (mon_on) begin
        if (gnt != 4'b0000 && prev_gnt == 4'b0000) gseq.push_back(gnt);
        prev_gnt = gnt;
        if (fifo_wr_en === 1'b1) dut_wr++;
        if (exp_cyc.size() > 0) begin
          ec = exp_cyc.pop_front();
          chk("gnt", gnt, ec.gnt);
          chk("busy", busy, ec.busy);
          chk("wr_en", fifo_wr_en, ec.wr);
          if (fifo_wr_en === 1'b1) begin
            if (exp_wr.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL write: unexpected write of %0h, none required", fifo_d_in);
            end else begin
              ew = exp_wr.pop_front();
              chk("ack", ack, 32'(1 << ew.idx));
              chk("d_in", fifo_d_in, ew.data);
            end
          end else begin
            chk("ack_idle", ack, 32'h0);
            chk("d_in_idle", fifo_d_in, 32'h0);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] rr_exp[5];
    int w0, n0;
    word_t w;
    logic [3:0] drop;
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1'b1; req = '0; req_last = '0; req_data = '0;
    fifo_full = 1'b0; fifo_wr_err = 1'b0;
    m_mode = 0; m_cur = 0; m_cnt = 0; m_ptr = 0;
    for (int i = 0; i < 4; i++) m_acc[i] = 0;
    @(posedge clk);
    mon_on = 1;

    // Reset held with all requesters asking, then round robin over 5 bursts
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 30; j++) pq[i].push_back('{32'(i * 256 + j), 1'b0});
    step(1, 0, 4'b0000);
    step(1, 0, 4'b0000);
    gseq.delete();
    repeat (32) step(0, 0, 4'b0000);
    #2;
    chk("rr_grant_count_ge5", 32'(gseq.size() >= 5), 32'h1);
    for (int k = 0; k < 5; k++)
      if (k < gseq.size()) chk($sformatf("rr_grant%0d", k), gseq[k], rr_exp[k]);

    // Reset in the middle of a burst
    clear_queues();
    step(1, 0, 4'b0000);

    // Early end: requester 2 sends two words, last on the second
    w0 = dut_wr;
    pq[2].push_back('{32'hA0, 1'b0});
    pq[2].push_back('{32'hA1, 1'b1});
    repeat (8) step(0, 0, 4'b0000);
    #2;
    chk("early_end_writes", dut_wr - w0, 2);

    // Full stall after the first word of a 4-word burst
    w0 = dut_wr;
    n0 = n_exp_wr;
    for (int j = 0; j < 4; j++) pq[0].push_back('{32'h100 + 32'(j), 1'b0});
    for (int t = 0; t < 10 && n_exp_wr == n0; t++) step(0, 0, 4'b0000);
    chk("stall_first_word", n_exp_wr - n0, 1);
    repeat (3) step(0, 1, 4'b0000);
    repeat (10) step(0, 0, 4'b0000);
    #2;
    chk("stall_data_count", dut_wr - w0, 4);

    // Abandon: requester 1 drops req after one ack, requester 2 goes next
    gseq.delete();
    n0 = n_exp_wr;
    for (int j = 0; j < 3; j++) pq[1].push_back('{32'h200 + 32'(j), 1'b0});
    for (int j = 0; j < 2; j++) pq[2].push_back('{32'h300 + 32'(j), 1'b0});
    for (int t = 0; t < 10 && n_exp_wr == n0; t++) step(0, 0, 4'b0000);
    repeat (3) step(0, 0, 4'b0010);
    repeat (20) step(0, 0, 4'b0000);
    #2;
    chk("abandon_grants_ge2", 32'(gseq.size() >= 2), 32'h1);
    if (gseq.size() >= 2) begin
      chk("abandon_first", gseq[0], 4'b0010);
      chk("abandon_next", gseq[1], 4'b0100);
    end

    // Random traffic with random full, req drops and one reset
    for (int t = 0; t < 1000; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (pq[i].size() < 6 && $urandom_range(0, 3) == 0) begin
          w.data = $urandom;
          w.last = ($urandom_range(0, 3) == 0);
          pq[i].push_back(w);
        end
      end
      drop = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
      step(t == 500, $urandom_range(0, 4) == 0, drop);
    end

`ifdef FIFO_WR_ARB_STATS_EN
    // Statistics: five words from requester 3, then a write-error pulse
    clear_queues();
    step(1, 0, 4'b0000);
    for (int j = 0; j < 5; j++) pq[3].push_back('{32'h400 + 32'(j), 1'b0});
    repeat (20) step(0, 0, 4'b0000);
    #2;
    chk("acc_cnt3", acc_cnt[63:48], 5);
    chk("acc_cnt0", acc_cnt[15:0], 0);
    chk("acc_cnt_model3", acc_cnt[63:48], m_acc[3]);
    chk("ovf_before", ovf_err, 0);
    err_now = 1'b1;
    step(0, 0, 4'b0000);
    err_now = 1'b0;
    step(0, 0, 4'b0000);
    #2;
    chk("ovf_set", ovf_err, 1);
    repeat (5) step(0, 0, 4'b0000);
    #2;
    chk("ovf_sticky", ovf_err, 1);
    step(1, 0, 4'b0000);
    step(0, 0, 4'b0000);
    #2;
    chk("ovf_cleared", ovf_err, 0);
    chk("acc_cleared", acc_cnt[63:48], 0);
`endif

    step(0, 0, 4'b0000);
    #2;
    chk("writes_all_seen", exp_wr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
